// File: rtl/bram_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : bram_pipelined
// Brief    : Synchronous-read block RAM with byte-enabled write port,
//            1- or 2-cycle read pipeline and a post-reset zeroing sweep.
// Revision : 1.0 - initial release
// ============================================================================
module bram_pipelined #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 12,
    parameter int DEPTH          = 1024,
    parameter int READ_LATENCY   = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    wr_req,
    input  logic [ADDR_WIDTH-1:0]   wr_addr,
    input  logic [DATA_WIDTH-1:0]   wr_data,
    input  logic [DATA_WIDTH/8-1:0] wr_be,
    output logic                    wr_ready,
    input  logic                    rd_req,
    input  logic [ADDR_WIDTH-1:0]   rd_addr,
    output logic                    rd_ready,
    output logic                    rd_valid,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    rd_err,
    output logic                    init_busy,
    input  logic [ADDR_WIDTH-1:0]   dbg_addr,
    output logic [DATA_WIDTH-1:0]   dbg_data
);
    localparam int c_BYTES = DATA_WIDTH / 8;
    localparam int c_LSB   = (c_BYTES > 1) ? $clog2(c_BYTES) : 0;
    localparam int c_IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    state_t               r_state;
    state_t               w_state_next;
    logic [c_IDX_W-1:0]   r_clr_cnt;
    logic [c_IDX_W-1:0]   w_clr_cnt_next;
    logic                 w_clr_we;
    logic                 w_ready;

    logic [31:0]          w_wr_idx;
    logic [31:0]          w_rd_idx;
    logic [31:0]          w_dbg_idx;
    logic                 w_wr_in;
    logic                 w_rd_in;
    logic                 w_dbg_in;
    logic                 w_wr_acc;
    logic                 w_rd_acc;
    logic [DATA_WIDTH-1:0] w_rd_word;

    logic                  r_s1_valid;
    logic [DATA_WIDTH-1:0] r_s1_data;
    logic                  r_s1_err;

    // Full-width word indices so out-of-range addresses never alias onto real words
    assign w_wr_idx  = 32'(wr_addr >> c_LSB);
    assign w_rd_idx  = 32'(rd_addr >> c_LSB);
    assign w_dbg_idx = 32'(dbg_addr >> c_LSB);
    assign w_wr_in   = (w_wr_idx < 32'(DEPTH));
    assign w_rd_in   = (w_rd_idx < 32'(DEPTH));
    assign w_dbg_in  = (w_dbg_idx < 32'(DEPTH));

    assign w_ready   = (r_state == S_READY) && !rst;
    assign wr_ready  = w_ready;
    assign rd_ready  = w_ready;
    assign init_busy = rst ? (CLEAR_ON_RESET != 0) : (r_state == S_INIT);
    assign w_wr_acc  = wr_req && w_ready;
    assign w_rd_acc  = rd_req && w_ready;

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_clr_we       = 1'b0;
        if (r_state == S_INIT) begin
            w_clr_we       = 1'b1;
            w_clr_cnt_next = r_clr_cnt + 1'b1;
            if (32'(r_clr_cnt) == 32'(DEPTH - 1)) begin
                w_state_next   = S_READY;
                w_clr_cnt_next = '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= (CLEAR_ON_RESET != 0) ? S_INIT : S_READY;
            r_clr_cnt <= '0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
        end
    end

    // Array has no reset; it is zeroed word by word by the sweep instead
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_we) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_wr_acc && w_wr_in) begin
                for (int k = 0; k < c_BYTES; k++) begin
                    if (wr_be[k]) begin
                        r_mem[w_wr_idx[c_IDX_W-1:0]][8*k +: 8] <= wr_data[8*k +: 8];
                    end
                end
            end
        end
    end

    // Write-first forwarding for a same-word read/write in one accept cycle
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in) begin
            w_rd_word = r_mem[w_rd_idx[c_IDX_W-1:0]];
            if (w_wr_acc && (w_wr_idx == w_rd_idx)) begin
                for (int k = 0; k < c_BYTES; k++) begin
                    if (wr_be[k]) begin
                        w_rd_word[8*k +: 8] = wr_data[8*k +: 8];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_data  <= '0;
            r_s1_err   <= 1'b0;
        end else begin
            r_s1_valid <= w_rd_acc;
            if (w_rd_acc) begin
                r_s1_data <= w_rd_word;
                r_s1_err  <= !w_rd_in;
            end
        end
    end

    generate
        if (READ_LATENCY == 2) begin : g_lat2
            logic                  r_s2_valid;
            logic [DATA_WIDTH-1:0] r_s2_data;
            logic                  r_s2_err;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s2_valid <= 1'b0;
                    r_s2_data  <= '0;
                    r_s2_err   <= 1'b0;
                end else begin
                    r_s2_valid <= r_s1_valid;
                    if (r_s1_valid) begin
                        r_s2_data <= r_s1_data;
                        r_s2_err  <= r_s1_err;
                    end
                end
            end

            assign rd_valid = r_s2_valid;
            assign rd_data  = r_s2_data;
            assign rd_err   = r_s2_err;
        end else begin : g_lat1
            assign rd_valid = r_s1_valid;
            assign rd_data  = r_s1_data;
            assign rd_err   = r_s1_err;
        end
    endgenerate

    assign dbg_data = w_dbg_in ? r_mem[w_dbg_idx[c_IDX_W-1:0]] : '0;

endmodule
`default_nettype wire

// File: tb/tb_bram_pipelined.sv
`default_nettype none
// ============================================================================
// Module   : tb_bram_pipelined
// Brief    : Self-checking bench: instance A (defaults, latency 1) and
//            instance B (512 words, latency 2) against a word-array model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_bram_pipelined;
    localparam int c_DEPTH_A = 1024;
    localparam int c_DEPTH_B = 512;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        a_wr_req, a_wr_ready, a_rd_req, a_rd_ready, a_rd_valid, a_rd_err, a_init_busy;
    logic [11:0] a_wr_addr, a_rd_addr, a_dbg_addr;
    logic [31:0] a_wr_data, a_rd_data, a_dbg_data;
    logic [3:0]  a_wr_be;
    logic        b_wr_req, b_wr_ready, b_rd_req, b_rd_ready, b_rd_valid, b_rd_err, b_init_busy;
    logic [11:0] b_wr_addr, b_rd_addr, b_dbg_addr;
    logic [31:0] b_wr_data, b_rd_data, b_dbg_data;
    logic [3:0]  b_wr_be;

    int n_checks = 0;
    int n_pass   = 0;

    logic [31:0] mem_a [c_DEPTH_A];
    logic [31:0] mem_b [c_DEPTH_B];

    bram_pipelined dut_a (
        .clk(clk), .rst(rst),
        .wr_req(a_wr_req), .wr_addr(a_wr_addr), .wr_data(a_wr_data), .wr_be(a_wr_be),
        .wr_ready(a_wr_ready), .rd_req(a_rd_req), .rd_addr(a_rd_addr), .rd_ready(a_rd_ready),
        .rd_valid(a_rd_valid), .rd_data(a_rd_data), .rd_err(a_rd_err), .init_busy(a_init_busy),
        .dbg_addr(a_dbg_addr), .dbg_data(a_dbg_data)
    );

    bram_pipelined #(.DEPTH(c_DEPTH_B), .READ_LATENCY(2)) dut_b (
        .clk(clk), .rst(rst),
        .wr_req(b_wr_req), .wr_addr(b_wr_addr), .wr_data(b_wr_data), .wr_be(b_wr_be),
        .wr_ready(b_wr_ready), .rd_req(b_rd_req), .rd_addr(b_rd_addr), .rd_ready(b_rd_ready),
        .rd_valid(b_rd_valid), .rd_data(b_rd_data), .rd_err(b_rd_err), .init_busy(b_init_busy),
        .dbg_addr(b_dbg_addr), .dbg_data(b_dbg_data)
    );

    // Returns {err, data} a read of raddr sees, given an optional same-cycle write
    function automatic logic [32:0] model_read(input bit is_b, input logic [11:0] raddr,
            input bit wr, input logic [11:0] waddr, input logic [31:0] wdata, input logic [3:0] be);
        int depth = is_b ? c_DEPTH_B : c_DEPTH_A;
        int ri = int'(raddr) / 4;
        int wi = int'(waddr) / 4;
        logic [31:0] word;
        if (ri >= depth) return {1'b1, 32'h0};
        word = is_b ? mem_b[ri] : mem_a[ri];
        if (wr && wi == ri)
            for (int k = 0; k < 4; k++) if (be[k]) word[8*k +: 8] = wdata[8*k +: 8];
        return {1'b0, word};
    endfunction

    task automatic model_write(input bit is_b, input logic [11:0] waddr,
            input logic [31:0] wdata, input logic [3:0] be);
        int wi = int'(waddr) / 4;
        for (int k = 0; k < 4; k++) begin
            if (be[k]) begin
                if (is_b) begin
                    if (wi < c_DEPTH_B) mem_b[wi][8*k +: 8] = wdata[8*k +: 8];
                end else begin
                    if (wi < c_DEPTH_A) mem_a[wi][8*k +: 8] = wdata[8*k +: 8];
                end
            end
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < c_DEPTH_A; i++) mem_a[i] = 32'h0;
        for (int i = 0; i < c_DEPTH_B; i++) mem_b[i] = 32'h0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one cycle on one instance and returns the model's read result
    task automatic op(input bit is_b, input bit wr, input logic [11:0] waddr,
            input logic [31:0] wdata, input logic [3:0] be, input bit rd,
            input logic [11:0] raddr, output logic [32:0] exp);
        if (is_b) begin
            b_wr_req = wr; b_wr_addr = waddr; b_wr_data = wdata; b_wr_be = be;
            b_rd_req = rd; b_rd_addr = raddr;
        end else begin
            a_wr_req = wr; a_wr_addr = waddr; a_wr_data = wdata; a_wr_be = be;
            a_rd_req = rd; a_rd_addr = raddr;
        end
        exp = model_read(is_b, raddr, wr, waddr, wdata, be);
        if (wr) model_write(is_b, waddr, wdata, be);
        tick();
        a_wr_req = 1'b0; a_rd_req = 1'b0; b_wr_req = 1'b0; b_rd_req = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while ((a_init_busy || b_init_busy) && n < 3000) begin
            tick();
            n++;
        end
        n_checks++;
        if (a_init_busy || b_init_busy) $display("FAIL wait_ready: sweep still busy after %0d cycles", n);
        else n_pass++;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({a_rd_valid, a_rd_err, a_wr_ready, a_rd_ready, a_init_busy} !== 5'b00001)
            $display("FAIL reset_a_flags: got %b want 00001", {a_rd_valid, a_rd_err, a_wr_ready, a_rd_ready, a_init_busy});
        else n_pass++;
        n_checks++;
        if (a_rd_data !== 32'h0) $display("FAIL reset_a_data: got %h want 0", a_rd_data); else n_pass++;
        n_checks++;
        if ({b_rd_valid, b_rd_err, b_wr_ready, b_rd_ready, b_init_busy} !== 5'b00001)
            $display("FAIL reset_b_flags: got %b want 00001", {b_rd_valid, b_rd_err, b_wr_ready, b_rd_ready, b_init_busy});
        else n_pass++;
        n_checks++;
        if (b_rd_data !== 32'h0) $display("FAIL reset_b_data: got %h want 0", b_rd_data); else n_pass++;
        rst = 1'b0;
        wait_ready();
        model_zero();
    endtask

    task automatic count_sweep(input string tag);
        int ca = 0, cb = 0, bad_rdy = 0;
        for (int i = 0; i < 3000 && (a_init_busy || b_init_busy); i++) begin
            if (a_init_busy) begin
                ca++;
                if (a_rd_ready || a_wr_ready) bad_rdy++;
            end
            if (b_init_busy) begin
                cb++;
                if (b_rd_ready || b_wr_ready) bad_rdy++;
            end
            tick();
        end
        n_checks++;
        if (ca != c_DEPTH_A) $display("FAIL %s_len_a: got %0d want %0d", tag, ca, c_DEPTH_A); else n_pass++;
        n_checks++;
        if (cb != c_DEPTH_B) $display("FAIL %s_len_b: got %0d want %0d", tag, cb, c_DEPTH_B); else n_pass++;
        n_checks++;
        if (bad_rdy != 0) $display("FAIL %s_ready_low: got %0d ready cycles want 0", tag, bad_rdy); else n_pass++;
        n_checks++;
        if (!(a_rd_ready && b_rd_ready)) $display("FAIL %s_ready_after: got %b%b want 11", tag, a_rd_ready, b_rd_ready);
        else n_pass++;
    endtask

    task automatic test_clear_sweep();
        logic [32:0] e;
        logic [32:0] prev;
        int bad;
        for (int i = 0; i < 16; i++) begin
            op(1'b0, 1'b1, 12'($urandom_range(0, 1023) * 4), $urandom | 32'h1, 4'hF, 1'b0, 12'h0, e);
            op(1'b1, 1'b1, 12'($urandom_range(0, 511) * 4), $urandom | 32'h1, 4'hF, 1'b0, 12'h0, e);
        end
        a_rd_req = 1'b1; a_rd_addr = 12'h0; b_rd_req = 1'b1; b_rd_addr = 12'h0;
        tick();
        a_rd_req = 1'b0; b_rd_req = 1'b0;
        n_checks++;
        if (a_rd_valid !== 1'b1) $display("FAIL inflight_a_pre: got %b want 1", a_rd_valid); else n_pass++;
        rst = 1'b1;
        tick();
        n_checks++;
        if ({a_rd_valid, b_rd_valid} !== 2'b00) $display("FAIL inflight_discard: got %b%b want 00", a_rd_valid, b_rd_valid);
        else n_pass++;
        tick();
        rst = 1'b0;
        count_sweep("sweep");
        rst = 1'b1;
        tick();
        rst = 1'b0;
        repeat (500) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        count_sweep("restart");
        model_zero();
        bad = 0;
        for (int i = 0; i < c_DEPTH_A; i++) begin
            op(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 12'(i * 4), e);
            if (a_rd_valid !== 1'b1 || a_rd_data !== 32'h0) bad++;
        end
        n_checks++;
        if (bad != 0) $display("FAIL clear_all_a: got %0d nonzero words want 0", bad); else n_pass++;
        bad = 0;
        for (int i = 0; i <= c_DEPTH_B; i++) begin
            op(1'b1, 1'b0, 12'h0, 32'h0, 4'h0, i < c_DEPTH_B, 12'(i * 4), e);
            if (i > 0 && (b_rd_valid !== 1'b1 || b_rd_data !== 32'h0)) bad++;
            prev = e;
        end
        n_checks++;
        if (bad != 0) $display("FAIL clear_all_b: got %0d nonzero words want 0", bad); else n_pass++;
    endtask

    task automatic test_byte_enables();
        logic [32:0] e;
        op(1'b0, 1'b1, 12'h010, 32'hAABBCCDD, 4'b1111, 1'b0, 12'h0, e);
        op(1'b0, 1'b1, 12'h010, 32'h11223344, 4'b0101, 1'b0, 12'h0, e);
        op(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 12'h010, e);
        n_checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 32'hAA22CC44 || a_rd_err !== 1'b0)
            $display("FAIL byte_enable: got v=%b d=%h e=%b want v=1 d=aa22cc44 e=0", a_rd_valid, a_rd_data, a_rd_err);
        else n_pass++;
    endtask

    task automatic test_collision();
        logic [32:0] e;
        op(1'b0, 1'b1, 12'h020, 32'h12345678, 4'hF, 1'b0, 12'h0, e);
        op(1'b0, 1'b1, 12'h020, 32'hFFFFFFFF, 4'b0011, 1'b1, 12'h020, e);
        n_checks++;
        if (a_rd_valid !== 1'b1 || a_rd_data !== 32'h1234FFFF)
            $display("FAIL collision_fwd: got v=%b d=%h want v=1 d=1234ffff", a_rd_valid, a_rd_data);
        else n_pass++;
        op(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 12'h020, e);
        n_checks++;
        if (a_rd_data !== 32'h1234FFFF) $display("FAIL collision_stored: got %h want 1234ffff", a_rd_data);
        else n_pass++;
    endtask

    task automatic test_streaming();
        logic [32:0] e;
        logic [31:0] vals [3];
        bit exp_v;
        for (int i = 0; i < 3; i++) begin
            vals[i] = $urandom;
            op(1'b0, 1'b1, 12'(i * 4), vals[i], 4'hF, 1'b0, 12'h0, e);
            op(1'b1, 1'b1, 12'(i * 4), vals[i] ^ 32'h5A5A5A5A, 4'hF, 1'b0, 12'h0, e);
        end
        for (int i = 0; i < 5; i++) begin
            op(1'b0, 1'b0, 12'h0, 32'h0, 4'h0, i < 3, 12'(i * 4), e);
            exp_v = (i < 3);
            n_checks++;
            if (a_rd_valid !== exp_v || (exp_v && a_rd_data !== vals[i]))
                $display("FAIL stream_l1_%0d: got v=%b d=%h want v=%b d=%h", i, a_rd_valid, a_rd_data, exp_v, vals[i % 3]);
            else n_pass++;
        end
        for (int i = 0; i < 6; i++) begin
            op(1'b1, 1'b0, 12'h0, 32'h0, 4'h0, i < 3, 12'(i * 4), e);
            exp_v = (i >= 1 && i <= 3);
            n_checks++;
            if (b_rd_valid !== exp_v || (exp_v && b_rd_data !== (vals[(i + 2) % 3] ^ 32'h5A5A5A5A)))
                $display("FAIL stream_l2_%0d: got v=%b d=%h want v=%b", i, b_rd_valid, b_rd_data, exp_v);
            else n_pass++;
        end
    endtask

    task automatic test_out_of_range();
        logic [32:0] e;
        logic [32:0] prev;
        int bad = 0;
        op(1'b1, 1'b1, 12'h800, 32'hDEADBEEF, 4'hF, 1'b0, 12'h0, e);
        for (int i = 0; i <= c_DEPTH_B; i++) begin
            op(1'b1, 1'b0, 12'h0, 32'h0, 4'h0, i < c_DEPTH_B, 12'(i * 4), e);
            if (i > 0 && (b_rd_valid !== 1'b1 || b_rd_data !== prev[31:0])) bad++;
            prev = e;
        end
        n_checks++;
        if (bad != 0) $display("FAIL oor_write_dropped: got %0d changed words want 0", bad); else n_pass++;
        op(1'b1, 1'b0, 12'h0, 32'h0, 4'h0, 1'b1, 12'h800, e);
        op(1'b1, 1'b0, 12'h0, 32'h0, 4'h0, 1'b0, 12'h0, e);
        n_checks++;
        if ({b_rd_valid, b_rd_err} !== 2'b11 || b_rd_data !== 32'h0)
            $display("FAIL oor_read: got v=%b e=%b d=%h want v=1 e=1 d=0", b_rd_valid, b_rd_err, b_rd_data);
        else n_pass++;
        tick();
        n_checks++;
        if ({b_rd_valid, b_rd_err} !== 2'b01 || b_rd_data !== 32'h0)
            $display("FAIL oor_hold: got v=%b e=%b d=%h want v=0 e=1 d=0", b_rd_valid, b_rd_err, b_rd_data);
        else n_pass++;
    endtask

    task automatic test_debug();
        logic [31:0] old = mem_a[255];
        a_dbg_addr = 12'h3FC;
        a_wr_req = 1'b1; a_wr_addr = 12'h3FC; a_wr_data = 32'hCAFEF00D; a_wr_be = 4'hF;
        #1;
        n_checks++;
        if (a_dbg_data !== old) $display("FAIL dbg_no_forward: got %h want %h", a_dbg_data, old); else n_pass++;
        model_write(1'b0, 12'h3FC, 32'hCAFEF00D, 4'hF);
        tick();
        a_wr_req = 1'b0;
        n_checks++;
        if (a_dbg_data !== 32'hCAFEF00D) $display("FAIL dbg_after_write: got %h want cafef00d", a_dbg_data);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [32:0] e;
        logic [32:0] prev;
        logic [32:0] last;
        bit rd, wr, prev_rd, have_last;
        for (int i = 0; i < 300; i++) begin
            rd = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            op(1'b0, wr, 12'($urandom_range(0, 63)), $urandom, 4'($urandom), rd, 12'($urandom_range(0, 63)), e);
            n_checks++;
            if (rd) begin
                if (a_rd_valid !== 1'b1 || {a_rd_err, a_rd_data} !== e)
                    $display("FAIL rand_a_%0d: got v=%b d=%h want v=1 d=%h", i, a_rd_valid, a_rd_data, e[31:0]);
                else n_pass++;
                last = e;
            end else begin
                if (a_rd_valid !== 1'b0 || {a_rd_err, a_rd_data} !== last)
                    $display("FAIL rand_a_hold_%0d: got v=%b d=%h want v=0 d=%h", i, a_rd_valid, a_rd_data, last[31:0]);
                else n_pass++;
            end
        end
        prev_rd = 1'b0;
        have_last = 1'b0;
        for (int i = 0; i < 300; i++) begin
            rd = (i == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            wr = 1'($urandom_range(0, 1));
            op(1'b1, wr, 12'(2040 + $urandom_range(0, 15)), $urandom, 4'($urandom), rd,
               12'(2040 + $urandom_range(0, 15)), e);
            if (prev_rd) begin
                n_checks++;
                if (b_rd_valid !== 1'b1 || {b_rd_err, b_rd_data} !== prev)
                    $display("FAIL rand_b_%0d: got v=%b e=%b d=%h want v=1 e=%b d=%h", i, b_rd_valid, b_rd_err, b_rd_data, prev[32], prev[31:0]);
                else n_pass++;
                last = prev;
                have_last = 1'b1;
            end else if (have_last) begin
                n_checks++;
                if (b_rd_valid !== 1'b0 || {b_rd_err, b_rd_data} !== last)
                    $display("FAIL rand_b_hold_%0d: got v=%b d=%h want v=0 d=%h", i, b_rd_valid, b_rd_data, last[31:0]);
                else n_pass++;
            end
            prev_rd = rd;
            prev = e;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        a_wr_req = 1'b0; a_wr_addr = '0; a_wr_data = '0; a_wr_be = '0;
        a_rd_req = 1'b0; a_rd_addr = '0; a_dbg_addr = '0;
        b_wr_req = 1'b0; b_wr_addr = '0; b_wr_data = '0; b_wr_be = '0;
        b_rd_req = 1'b0; b_rd_addr = '0; b_dbg_addr = '0;
        test_reset();
        test_clear_sweep();
        test_byte_enables();
        test_collision();
        test_streaming();
        test_out_of_range();
        test_debug();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
